// File: rtl/filterbank_aligner.sv
// Regroups filter-bank output samples into channel-ordered frames of N samples,
// using ping-pong banks so one frame fills while the previous one is read out.
module filterbank_aligner #(
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int WDTH  = 32,
    parameter int MWDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WDTH-1:0]  in_data,
    input  logic             in_nd,
    input  logic [MWDTH-1:0] in_m,
    input  logic             in_first,
    output logic [WDTH-1:0]  out_data,
    output logic             out_nd,
    output logic [MWDTH-1:0] out_m,
    output logic             out_first,
    output logic             error,
    output logic [1:0]       dbg_state
);
    // Handshake: in_nd qualifies in_data/in_m/in_first for exactly one cycle and
    // out_nd qualifies out_data/out_m/out_first likewise; there is no ready, so
    // every qualified input sample is consumed in the cycle it is presented.

    typedef enum logic {SEARCH = 1'b0, FILL = 1'b1} state_t;

    localparam int              DW   = WDTH + MWDTH;
    localparam logic [LOG_N:0]  N_L  = (LOG_N+1)'(N);
    localparam logic [LOG_N-1:0] N_M1 = LOG_N'(N - 1);

    state_t             state;
    logic [LOG_N-1:0]   widx;
    logic               fill_bank;
    logic               rd_active;
    logic               rd_bank;
    logic [LOG_N-1:0]   rd_cnt;

    logic [DW-1:0]      mem [0:2*N-1];

    logic [LOG_N-1:0]   wr_idx;
    logic [LOG_N:0]     wr_addr;
    logic               we;
    logic               err_now;
    logic               complete;

    // Bank 0 occupies entries 0..N-1, bank 1 occupies N..2N-1.
    function automatic logic [LOG_N:0] bank_addr(input logic bank, input logic [LOG_N-1:0] idx);
        return bank ? ({1'b0, idx} + N_L) : {1'b0, idx};
    endfunction

    always_comb begin
        wr_idx  = in_first ? '0 : widx;
        we      = 1'b0;
        err_now = 1'b0;
        if (in_nd) begin
            if (state == SEARCH) begin
                we = in_first;
            end else if (in_first || widx != '0) begin
                we      = 1'b1;
                err_now = in_first && (widx != '0);
            end else begin
                err_now = 1'b1;
            end
        end
        complete = we && (wr_idx == N_M1);
        wr_addr  = bank_addr(fill_bank, wr_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            widx      <= '0;
            fill_bank <= 1'b0;
            error     <= 1'b0;
        end else begin
            error <= err_now;
            if (err_now && !we) begin
                state <= SEARCH;
                widx  <= '0;
            end else if (we) begin
                state <= FILL;
                widx  <= complete ? '0 : wr_idx + 1'b1;
                if (complete) begin
                    fill_bank <= ~fill_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= {in_data, in_m};
        end
    end

    // Channel 0 of the completed bank is already stored, so it is launched on the
    // same edge that writes channel N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_active <= 1'b0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            out_data  <= '0;
            out_m     <= '0;
            out_nd    <= 1'b0;
            out_first <= 1'b0;
        end else if (complete) begin
            rd_active             <= 1'b1;
            rd_bank               <= fill_bank;
            rd_cnt                <= LOG_N'(1);
            {out_data, out_m}     <= mem[bank_addr(fill_bank, '0)];
            out_nd                <= 1'b1;
            out_first             <= 1'b1;
        end else if (rd_active) begin
            {out_data, out_m}     <= mem[bank_addr(rd_bank, rd_cnt)];
            out_nd                <= 1'b1;
            out_first             <= 1'b0;
            if (rd_cnt == N_M1) begin
                rd_active <= 1'b0;
                rd_cnt    <= '0;
            end else begin
                rd_cnt    <= rd_cnt + 1'b1;
            end
        end else begin
            out_data  <= '0;
            out_m     <= '0;
            out_nd    <= 1'b0;
            out_first <= 1'b0;
        end
    end

    assign dbg_state = {rd_active, state == FILL};

endmodule

// File: tb/tb_filterbank_aligner.sv
// Bench for filterbank_aligner: table of aligned vectors, hand-written corner
// sequences and a randomized run against a queue-based frame model.
module tb_filterbank_aligner;
    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int WDTH  = 32;
    localparam int MWDTH = 1;
    localparam int SW    = WDTH + MWDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [WDTH-1:0]  in_data;
    logic             in_nd;
    logic [MWDTH-1:0] in_m;
    logic             in_first;
    logic [WDTH-1:0]  out_data;
    logic             out_nd;
    logic [MWDTH-1:0] out_m;
    logic             out_first;
    logic             error;
    logic [1:0]       dbg_state;

    filterbank_aligner #(.N(N), .LOG_N(LOG_N), .WDTH(WDTH), .MWDTH(MWDTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
        .in_first(in_first), .out_data(out_data), .out_nd(out_nd), .out_m(out_m),
        .out_first(out_first), .error(error), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a partially collected frame and a queue of scheduled outputs.
    logic [SW-1:0]   part_q[$];
    logic [SW:0]     exp_q[$];
    logic            m_in_frame;
    logic            e_nd, e_first, e_err;
    logic [WDTH-1:0] e_data;
    logic [MWDTH-1:0] e_m;

    logic [WDTH-1:0] out_log[$];
    int              err_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic nd, input logic f,
                              input logic [WDTH-1:0] d, input logic [MWDTH-1:0] m);
        logic [SW:0] e;
        e_err = 1'b0;
        if (r) begin
            part_q.delete();
            exp_q.delete();
            m_in_frame = 1'b0;
        end else if (nd) begin
            if (!m_in_frame) begin
                if (f) begin
                    part_q.delete();
                    part_q.push_back({d, m});
                    m_in_frame = 1'b1;
                end
            end else if (f) begin
                if (part_q.size() != 0) e_err = 1'b1;
                part_q.delete();
                part_q.push_back({d, m});
            end else if (part_q.size() == 0) begin
                e_err = 1'b1;
                m_in_frame = 1'b0;
            end else begin
                part_q.push_back({d, m});
            end
            if (part_q.size() == N) begin
                for (int k = 0; k < N; k++) exp_q.push_back({k == 0, part_q[k]});
                part_q.delete();
            end
        end
        if (!r && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            e_nd    = 1'b1;
            e_first = e[SW];
            e_data  = e[SW-1:MWDTH];
            e_m     = e[MWDTH-1:0];
        end else begin
            e_nd = 1'b0; e_first = 1'b0; e_data = '0; e_m = '0;
        end
    endtask

    task automatic tick(input logic r, input logic nd, input logic f,
                        input logic [WDTH-1:0] d, input logic [MWDTH-1:0] m);
        rst = r; in_nd = nd; in_first = f; in_data = d; in_m = m;
        model_step(r, nd, f, d, m);
        @(posedge clk);
        @(negedge clk);
        check("out_nd", 64'(out_nd), 64'(e_nd));
        check("out_first", 64'(out_first), 64'(e_first));
        check("out_data", 64'(out_data), 64'(e_data));
        check("out_m", 64'(out_m), 64'(e_m));
        check("error", 64'(error), 64'(e_err));
        if (out_nd) out_log.push_back(out_data);
        if (error) err_seen++;
    endtask

    task automatic restart();
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        out_log.delete();
        err_seen = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic frame(input int base);
        for (int i = 0; i < N; i++) tick(1'b0, 1'b1, i == 0, WDTH'(base + i), MWDTH'(i % 2));
    endtask

    typedef struct {
        logic             nd;
        logic             first;
        logic [WDTH-1:0]  data;
        logic [MWDTH-1:0] m;
        logic             exp_nd;
        logic             exp_first;
        logic [WDTH-1:0]  exp_data;
        logic [MWDTH-1:0] exp_m;
        logic             exp_err;
    } vec_t;

    vec_t vecs[26];

    initial begin
        int ch;
        logic r, nd, f;
        m_in_frame = 1'b0;
        err_seen = 0;

        // Two aligned back-to-back frames carrying 0..15; output lags by 7 samples.
        for (int i = 0; i < 26; i++) begin
            vecs[i].nd        = (i < 16);
            vecs[i].first     = (i == 0 || i == 8);
            vecs[i].data      = WDTH'(i);
            vecs[i].m         = MWDTH'(i % 2);
            vecs[i].exp_nd    = (i >= 7 && i <= 22);
            vecs[i].exp_first = (i == 7 || i == 15);
            vecs[i].exp_data  = vecs[i].exp_nd ? WDTH'(i - 7) : '0;
            vecs[i].exp_m     = vecs[i].exp_nd ? MWDTH'((i - 7) % 2) : '0;
            vecs[i].exp_err   = 1'b0;
        end

        tick(1'b1, 1'b0, 1'b0, '0, '0);
        tick(1'b1, 1'b1, 1'b1, 32'hdead, 1'b1);
        check("reset_out_nd", 64'(out_nd), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_error", 64'(error), 64'd0);

        for (int i = 0; i < 26; i++) begin
            tick(1'b0, vecs[i].nd, vecs[i].first, vecs[i].data, vecs[i].m);
            check("vec_nd", 64'(out_nd), 64'(vecs[i].exp_nd));
            check("vec_first", 64'(out_first), 64'(vecs[i].exp_first));
            check("vec_data", 64'(out_data), 64'(vecs[i].exp_data));
            check("vec_m", 64'(out_m), 64'(vecs[i].exp_m));
            check("vec_err", 64'(error), 64'(vecs[i].exp_err));
        end

        // Misaligned lead-in is dropped quietly.
        restart();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, WDTH'(100 + i), '0);
        frame(200);
        idle(10);
        check("lead_in_err", 64'(err_seen), 64'd0);
        check("lead_in_count", 64'(out_log.size()), 64'(N));
        if (out_log.size() > 0) check("lead_in_first", 64'(out_log[0]), 64'd200);

        // Early restart at widx=5 discards the partial frame.
        restart();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, i == 0, WDTH'(300 + i), '0);
        frame(310);
        idle(10);
        check("early_err", 64'(err_seen), 64'd1);
        check("early_count", 64'(out_log.size()), 64'(N));
        if (out_log.size() > 0) check("early_first", 64'(out_log[0]), 64'd310);

        // Missing in_first at a frame boundary drops back to search.
        restart();
        frame(400);
        tick(1'b0, 1'b1, 1'b0, 32'd500, '0);
        tick(1'b0, 1'b1, 1'b0, 32'd501, '0);
        frame(600);
        idle(10);
        check("boundary_err", 64'(err_seen), 64'd1);
        check("boundary_count", 64'(out_log.size()), 64'(2 * N));
        if (out_log.size() > N) check("boundary_next", 64'(out_log[N]), 64'd600);

        // Gapped input, alternating metadata: bursts remain contiguous.
        restart();
        for (int i = 0; i < 2 * N; i++) begin
            tick(1'b0, 1'b1, (i % N) == 0, WDTH'(900 + i), MWDTH'(i % 2));
            idle(2);
        end
        idle(10);
        check("gapped_count", 64'(out_log.size()), 64'(2 * N));

        // Reset during readout of channel 3.
        restart();
        frame(700);
        idle(3);
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        check("rst_mid_nd", 64'(out_nd), 64'd0);
        idle(4);
        frame(800);
        idle(10);
        check("rst_mid_count", 64'(out_log.size()), 64'(4 + N));
        if (out_log.size() > 4) check("rst_mid_recover", 64'(out_log[4]), 64'd800);

        // Randomized stream with occasional glitches, gaps and resets.
        ch = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            nd = ($urandom_range(0, 3) != 0);
            f  = (ch == 0);
            if ($urandom_range(0, 39) == 0) f = ~f;
            if (nd) ch = f ? 1 : (ch + 1) % N;
            if (r) ch = 0;
            tick(r, nd, f, $urandom, MWDTH'($urandom_range(0, 1)));
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
